// File: rtl/onchip_mem_block_reader.sv
// Purpose: streams a contiguous block of on-chip RAM words out as one framed packet.
// Latency: first word on st_data three cycles after start; one word per cycle after that.
// Backpressure: st_ready low stalls reads once FIFO entries plus the read in flight reach FIFO_DEPTH.

module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic                       head_vld,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign pop_ok   = pop && (count != '0);
    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end
endmodule

module onchip_mem_block_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 5120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_startofpacket,
    output logic              st_endofpacket
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   out_cnt_q;
    logic              inflight_q;
    logic              done_q;
    logic              err_q;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic [ADDR_W+1:0] end_addr;
    logic              range_bad;
    logic              issue;
    logic              pop;
    logic              last_pop;

    // Sum is one bit wider than the operands so an oversized length cannot wrap into range.
    assign end_addr  = {2'b00, base_addr} + {1'b0, length};
    assign range_bad = end_addr > (ADDR_W+2)'(MEM_WORDS);
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};

    assign pop      = st_valid && st_ready;
    assign last_pop = pop && st_endofpacket;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (length != '0) && !range_bad) state_d = READ;
            end
            READ: begin
                if (occupancy < (CW+1)'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= issue;
            if (state_q == IDLE && start) begin
                if (length == '0) begin
                    done_q <= 1'b1;
                end else if (range_bad) begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                end else begin
                    addr_q    <= base_addr;
                    rem_q     <= length;
                    len_q     <= length;
                    out_cnt_q <= '0;
                end
            end
            if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - (ADDR_W+1)'(1);
            end
            if (last_pop) begin
                done_q    <= 1'b1;
                out_cnt_q <= '0;
            end else if (pop) begin
                out_cnt_q <= out_cnt_q + (ADDR_W+1)'(1);
            end
        end
    end

    // Read data lands one cycle after chipselect; credits guarantee the FIFO has room.
    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (inflight_q),
        .push_dat (mem_readdata),
        .pop      (pop),
        .head_dat (st_data),
        .head_vld (st_valid),
        .count    (fifo_count)
    );

    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign err              = err_q;
    assign mem_address      = addr_q;
    assign mem_chipselect   = issue;
    assign mem_write        = 1'b0;
    assign mem_byteenable   = 4'hF;
    assign mem_clken        = reset_n;
    assign st_startofpacket = st_valid && (out_cnt_q == '0);
    assign st_endofpacket   = st_valid && (out_cnt_q == len_q - (ADDR_W+1)'(1));
endmodule

// File: tb/tb_onchip_mem_block_reader.sv
// Bench for onchip_mem_block_reader: RAM model plus a word-list reference of each packet,
// directed cases followed by randomized transfers under random backpressure.
module tb_onchip_mem_block_reader;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 32;
    localparam int MEM_WORDS  = 5120;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy, done, err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic [DATA_W-1:0] st_data;
    logic              st_valid, st_ready;
    logic              st_startofpacket, st_endofpacket;

    logic [DATA_W-1:0] ram [MEM_WORDS];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    onchip_mem_block_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .err(err),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_startofpacket(st_startofpacket), .st_endofpacket(st_endofpacket)
    );

    // One-cycle read latency RAM
    always @(posedge clk) begin
        if (mem_chipselect)
            mem_readdata <= (int'(mem_address) < MEM_WORDS) ? ram[mem_address] : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 1) return !(cyc >= 3 && cyc <= 12);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    // mode 0: always ready, 1: stall cycles 3..12, 2: random stalls
    task automatic run_xfer(input int base, input int len, input int mode);
        int  issues = 0, pops = 0, done_cyc = -1, budget;
        bit  exp_err, legal, seen_vld = 0, done_seen = 0, noisy = 0;
        logic got_err = 1'b0;
        exp_err = (base + len > MEM_WORDS);
        legal   = (len != 0) && !exp_err;
        budget  = 60 + 6 * len;
        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR_W'(base); length = (ADDR_W+1)'(len);
        st_ready = ready_for(mode, 0);
        for (int cyc = 0; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("busy_c1", busy, legal);
            if (mem_chipselect) begin
                check("rd_addr", mem_address, base + issues);
                check("credit", (issues - pops) < FIFO_DEPTH, 1);
                issues++;
            end
            if (st_valid) seen_vld = 1;
            if (st_valid && st_ready) begin
                if (pops >= len) check("extra_word", pops, len - 1);
                else begin
                    check("data", st_data, ram[base + pops]);
                    check("sop", st_startofpacket, pops == 0);
                    check("eop", st_endofpacket, pops == len - 1);
                    if (mode == 0) check("no_gap_cycle", cyc, pops + 3);
                end
                pops++;
            end
            if (done) begin
                done_seen = 1; done_cyc = cyc; got_err = err;
                check("busy_at_done", busy, 0);
                break;
            end
            @(posedge clk); #1;
            start = (legal && cyc + 1 == 2);
            base_addr = '0; length = '0;
            st_ready = ready_for(mode, cyc + 1);
        end
        check("done_seen", done_seen, 1);
        if (done_seen) begin
            check("err", got_err, exp_err);
            if (mode == 0) check("done_cycle", done_cyc, legal ? len + 3 : 1);
        end
        check("words_out", pops, legal ? len : 0);
        check("reads", issues, legal ? len : 0);
        if (!legal) check("no_valid", seen_vld, 0);
        @(posedge clk); #1; start = 1'b0; st_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || st_valid || busy || mem_chipselect) noisy = 1;
        end
        check("quiet_after_done", noisy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outs"},
              {busy, done, err, mem_chipselect, st_valid, st_startofpacket, st_endofpacket, mem_clken},
              8'h00);
        check({tag, "_addr"}, mem_address, 0);
        check({tag, "_data"}, st_data, 0);
    endtask

    initial begin
        bit stray;
        int b, l;
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'hA500_0000 + i;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; st_ready = 1'b1;
        #12;
        check_reset_outputs("por");
        check("static_pins", {mem_write, mem_byteenable}, 5'b0_1111);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("clken_out_of_reset", mem_clken, 1);

        run_xfer(16, 8, 0);
        run_xfer(16, 8, 1);
        run_xfer(5119, 1, 0);
        run_xfer(5119, 2, 0);
        run_xfer(0, 0, 0);
        run_xfer(5112, 8, 0);
        run_xfer(100, 1, 1);

        // Reset in cycle 5 of a long transfer
        @(posedge clk); #1; start = 1'b1; base_addr = '0; length = 14'd100; st_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (st_valid || busy || done || mem_chipselect) stray = 1;
        end
        check("idle_after_reset", stray, 0);
        run_xfer(0, 3, 0);

        for (int i = 0; i < MEM_WORDS; i++) ram[i] = $urandom;
        for (int t = 0; t < 14; t++) begin
            l = $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) b = MEM_WORDS - $urandom_range(0, 40);
            else b = $urandom_range(0, MEM_WORDS - 1);
            run_xfer(b, l, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
